fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of first fetch after reset or load.
REQ-002 Parameter MEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_req  input  1  request to enter program-load mode.
REQ-006 ld_valid  input  1  loader word valid.
REQ-007 ld_data  input  32  loader instruction word.
REQ-008 ld_last  input  1  marks final loader word.
REQ-009 ld_ready  output  1  controller accepts loader word.
REQ-010 stall  input  1  pipeline cannot accept a new instruction.
REQ-011 redirect  input  1  branch/jump taken.
REQ-012 redirect_pc  input  32  redirect target byte address.
REQ-013 halt  input  1  stop fetching (ebreak/ecall).
REQ-014 imem_addr  output  32  byte address to instruction memory (memory uses addr[7:2]).
REQ-015 imem_we  output  1  instruction memory write enable.
REQ-016 imem_wdata  output  32  instruction memory write data.
REQ-017 imem_rdata  input  32  combinational read data from instruction memory.
REQ-018 if_valid  output  1  if_inst/if_pc hold a valid fetched instruction.
REQ-019 if_pc  output  32  address of if_inst.
REQ-020 if_inst  output  32  fetched instruction.
REQ-021 state  output  2  IDLE=00, LOAD=01, RUN=10, HALT=11.
REQ-022 misalign_err  output  1  sticky: redirect target not word-aligned.

Function
REQ-023 FSM transitions: IDLE -> LOAD if load_req, else IDLE -> RUN next cycle; LOAD -> RUN on accepted final word; RUN -> HALT on halt or misaligned redirect; HALT -> LOAD on load_req; no other transitions.
REQ-024 load_req SHALL be ignored in RUN and LOAD.
REQ-025 LOAD: ld_ready=1 combinationally; a word is accepted when ld_valid & ld_ready.
REQ-026 On acceptance, same cycle: imem_we=1, imem_addr={load_ptr,2'b00}, imem_wdata=ld_data; load_ptr increments at clock edge.
REQ-027 Final word = ld_last accepted, or word accepted at load_ptr==MEM_WORDS-1; then state<=RUN, pc<=RESET_PC, load_ptr<=0.
REQ-028 imem_we SHALL be 0 in every state except on an accepted LOAD cycle; imem_wdata=0 when imem_we=0.
REQ-029 RUN: imem_addr=pc combinationally; on each non-stalled cycle if_inst<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (modulo 2^32 wrap); fetch latency one cycle.
REQ-030 Stall (no redirect): pc, if_inst, if_pc, if_valid SHALL hold.
REQ-031 Redirect has priority over stall: pc<=redirect_pc, if_valid<=0 (one bubble); if_inst/if_pc hold.
REQ-032 Redirect with redirect_pc[1:0]!=0: misalign_err<=1, state<=HALT, pc unchanged.
REQ-033 halt has priority over redirect and stall: state<=HALT, if_valid<=0, pc holds.
REQ-034 Addresses beyond MEM_WORDS*4 bytes alias via addr[7:2]; no error raised.
REQ-035 In IDLE, LOAD and HALT: if_valid=0, imem_addr=pc unless writing.
REQ-036 misalign_err clears only on reset or entry into LOAD.

Reset
REQ-037 On rst=1 at clock edge: state=IDLE, pc=RESET_PC, load_ptr=0, if_valid=0, if_pc=0, if_inst=0, misalign_err=0; rst overrides all inputs, including mid-LOAD and mid-RUN.
REQ-038 Combinational outputs after reset: ld_ready=0, imem_we=0, imem_wdata=0, imem_addr=RESET_PC.

Verification
REQ-039 Reset, load_req=0: cycle1 IDLE, cycle2 RUN imem_addr=0, cycle3 if_valid=1 if_pc=0, cycle4 if_pc=4.
REQ-040 load_req, 3 words AAAA0001..AAAA0003 with ld_last on third, ld_valid gap in between -> writes at 0x0,0x4,0x8 only on valid cycles, then RUN fetching 0x0.
REQ-041 64 words without ld_last -> 64th write at 0xFC, automatic RUN, load_ptr=0.
REQ-042 RUN, stall=1 for 3 cycles -> if_pc/if_inst frozen; stall+redirect to 0x40 -> next cycle if_valid=0, following cycle if_pc=0x40.
REQ-043 redirect_pc=0x42 -> misalign_err=1, state=HALT; then load_req -> LOAD, misalign_err=0.
REQ-044 rst asserted mid-LOAD after 2 words -> IDLE, load_ptr=0, imem_we=0 next cycle.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: program loader into instruction memory,
// sequential fetch with stall/redirect/halt handling, one-cycle fetch latency.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | after reset; goes to LOAD on load_req, otherwise RUN
//  LOAD  | accepting loader words and writing them to instruction memory
//  RUN   | fetching from pc every non-stalled cycle
//  HALT  | fetching stopped (halt or misaligned redirect); waits for load_req
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [1:0]  state,
    output logic        misalign_err
);

    localparam int PTR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t           st;
    logic [31:0]      pc;
    logic [PTR_W-1:0] load_ptr;
    logic             accept;
    logic             final_word;
    logic [31:0]      load_addr;

    assign state      = st;
    assign ld_ready   = (st == S_LOAD);
    assign accept     = ld_ready & ld_valid;
    // Loading also ends automatically when the last memory word is written.
    assign final_word = ld_last | (load_ptr == LAST_PTR);
    assign load_addr  = {{(30 - PTR_W){1'b0}}, load_ptr, 2'b00};

    // Memory port: the loader owns the port only on accepted cycles; otherwise it reads at pc.
    always_comb begin
        imem_we    = accept;
        imem_wdata = accept ? ld_data : 32'h0;
        imem_addr  = accept ? load_addr : pc;
    end

    // Controller state, program counter, loader pointer and fetch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= S_IDLE;
            pc           <= RESET_PC;
            load_ptr     <= '0;
            if_valid     <= 1'b0;
            if_pc        <= 32'h0;
            if_inst      <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (load_req) begin
                        st           <= S_LOAD;
                        load_ptr     <= '0;
                        misalign_err <= 1'b0;
                    end else begin
                        st <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (final_word) begin
                            st       <= S_RUN;
                            pc       <= RESET_PC;
                            load_ptr <= '0;
                        end else begin
                            load_ptr <= load_ptr + PTR_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    // Priority: halt, then redirect, then stall.
                    if (halt) begin
                        st       <= S_HALT;
                        if_valid <= 1'b0;
                    end else if (redirect) begin
                        if_valid <= 1'b0;
                        if (redirect_pc[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                            st           <= S_HALT;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (!stall) begin
                        if_inst  <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + 32'd4;
                    end
                end
                S_HALT: begin
                    if (load_req) begin
                        st           <= S_LOAD;
                        load_ptr     <= '0;
                        misalign_err <= 1'b0;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural instruction memory,
// a write scoreboard for the loader and a fetch scoreboard for RUN.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        load_req;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  state;
    logic        misalign_err;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_we     (imem_we),
        .imem_wdata  (imem_wdata),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .state       (state),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural instruction memory: combinational read, clocked write.
    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr[7:2]];
    always @(posedge clk) begin
        if (imem_we) mem[imem_addr[7:2]] <= imem_wdata;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } pair_t;

    pair_t       wq[$];
    pair_t       fq[$];
    logic [31:0] exp_mem [64];
    logic [31:0] pc_m;
    logic [31:0] lp;
    logic [31:0] last_pc;
    logic [31:0] last_inst;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One loader cycle; an offered word is expected to be written at the bench's pointer.
    task automatic load_word(input logic [31:0] d, input logic last, input logic v);
        pair_t p;
        ld_valid = v;
        ld_data  = d;
        ld_last  = last;
        if (v) begin
            wq.push_back(pair_t'{lp << 2, d});
            exp_mem[lp[5:0]] = d;
            lp = lp + 1;
        end
        settle();
        chk("ld_ready", {31'h0, ld_ready}, 32'h1);
        chk("imem_we", {31'h0, imem_we}, {31'h0, v});
        if (imem_we) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", 32'h1, 32'h0);
            end else begin
                p = wq.pop_front();
                chk("wr_addr", imem_addr, p.a);
                chk("wr_data", imem_wdata, p.d);
            end
        end else begin
            chk("wdata_idle", imem_wdata, 32'h0);
        end
        nxt();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // n unstalled RUN cycles; each one should present the fetched word one cycle later.
    task automatic run_fetch(input int n);
        pair_t e;
        for (int i = 0; i < n; i++) begin
            fq.push_back(pair_t'{pc_m, exp_mem[pc_m[7:2]]});
            settle();
            chk("fetch_addr", imem_addr, pc_m);
            pc_m = pc_m + 32'd4;
            nxt();
            chk("if_valid", {31'h0, if_valid}, 32'h1);
            if (fq.size() == 0) begin
                chk("fetch_unexpected", 32'h1, 32'h0);
            end else begin
                e = fq.pop_front();
                chk("if_pc", if_pc, e.a);
                chk("if_inst", if_inst, e.d);
                last_pc   = e.a;
                last_inst = e.d;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
        rst = 1'b1; load_req = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        lp = 0; pc_m = 0; last_pc = 0; last_inst = 0;
        nxt();
        nxt();

        // Reset state
        chk("rst_state", {30'h0, state}, 32'h0);
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_imem_we", {31'h0, imem_we}, 32'h0);
        chk("rst_imem_wdata", imem_wdata, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);

        // Boot without load: IDLE, then RUN, then sequential fetch
        rst = 1'b0;
        settle();
        chk("boot_idle", {30'h0, state}, 32'h0);
        nxt();
        chk("boot_run", {30'h0, state}, 32'h2);
        chk("boot_addr", imem_addr, 32'h0);
        nxt();
        chk("boot_if_valid", {31'h0, if_valid}, 32'h1);
        chk("boot_if_pc0", if_pc, 32'h0);
        nxt();
        chk("boot_if_pc4", if_pc, 32'h4);

        // load_req ignored in RUN
        load_req = 1'b1;
        nxt();
        load_req = 1'b0;
        chk("run_ignores_load", {30'h0, state}, 32'h2);
        chk("run_pc12", imem_addr, 32'hC);

        // halt, then load three words with gaps
        halt = 1'b1;
        nxt();
        halt = 1'b0;
        chk("halt_state", {30'h0, state}, 32'h3);
        chk("halt_if_valid", {31'h0, if_valid}, 32'h0);
        chk("halt_pc_hold", imem_addr, 32'hC);
        load_req = 1'b1;
        nxt();
        load_req = 1'b0;
        chk("enter_load", {30'h0, state}, 32'h1);
        lp = 0;
        load_word(32'hAAAA_0001, 1'b0, 1'b1);
        load_word(32'hDEAD_BEEF, 1'b0, 1'b0);
        load_word(32'hAAAA_0002, 1'b0, 1'b1);
        load_word(32'hDEAD_BEEF, 1'b1, 1'b0);
        load_word(32'hAAAA_0003, 1'b1, 1'b1);
        chk("load3_run", {30'h0, state}, 32'h2);
        chk("load3_pc", imem_addr, 32'h0);
        pc_m = 0; lp = 0;
        run_fetch(3);

        // 64 words without ld_last
        halt = 1'b1;
        nxt();
        halt = 1'b0;
        load_req = 1'b1;
        nxt();
        load_req = 1'b0;
        chk("enter_load64", {30'h0, state}, 32'h1);
        for (int i = 0; i < 64; i++) load_word(32'hC0DE_0000 + 32'(i), 1'b0, 1'b1);
        chk("load64_run", {30'h0, state}, 32'h2);
        chk("load64_pc", imem_addr, 32'h0);
        pc_m = 0; lp = 0;
        run_fetch(3);

        // Stall holds fetch registers and pc
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("stall_if_pc", if_pc, last_pc);
            chk("stall_if_inst", if_inst, last_inst);
            chk("stall_pc", imem_addr, pc_m);
        end
        // Redirect wins over stall, one bubble
        redirect = 1'b1; redirect_pc = 32'h40;
        nxt();
        redirect = 1'b0; stall = 1'b0;
        chk("redir_bubble", {31'h0, if_valid}, 32'h0);
        chk("redir_if_pc_hold", if_pc, last_pc);
        chk("redir_pc", imem_addr, 32'h40);
        pc_m = 32'h40;
        run_fetch(2);

        // Address aliasing beyond memory depth
        redirect = 1'b1; redirect_pc = 32'h100;
        nxt();
        redirect = 1'b0;
        pc_m = 32'h100;
        run_fetch(1);

        // Misaligned redirect halts with sticky error
        redirect = 1'b1; redirect_pc = 32'h42;
        nxt();
        redirect = 1'b0;
        chk("mis_err", {31'h0, misalign_err}, 32'h1);
        chk("mis_state", {30'h0, state}, 32'h3);
        chk("mis_pc_hold", imem_addr, pc_m);
        chk("mis_if_valid", {31'h0, if_valid}, 32'h0);
        nxt();
        chk("mis_sticky", {31'h0, misalign_err}, 32'h1);
        load_req = 1'b1;
        nxt();
        load_req = 1'b0;
        chk("mis_load_state", {30'h0, state}, 32'h1);
        chk("mis_cleared", {31'h0, misalign_err}, 32'h0);

        // Reset in the middle of a load
        lp = 0;
        load_word(32'hBBBB_0001, 1'b0, 1'b1);
        load_word(32'hBBBB_0002, 1'b0, 1'b1);
        ld_valid = 1'b1; ld_data = 32'hBBBB_0003; rst = 1'b1;
        nxt();
        settle();
        chk("rstld_state", {30'h0, state}, 32'h0);
        chk("rstld_we", {31'h0, imem_we}, 32'h0);
        chk("rstld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rstld_wdata", imem_wdata, 32'h0);
        chk("rstld_addr", imem_addr, 32'h0);
        rst = 1'b0; ld_valid = 1'b0; lp = 0;
        nxt();
        chk("rstld_run", {30'h0, state}, 32'h2);
        pc_m = 0;
        run_fetch(2);

        // halt beats redirect and stall
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
        nxt();
        halt = 1'b0; redirect = 1'b0; stall = 1'b0;
        chk("hprio_state", {30'h0, state}, 32'h3);
        chk("hprio_if_valid", {31'h0, if_valid}, 32'h0);
        chk("hprio_pc", imem_addr, pc_m);
        chk("hprio_no_err", {31'h0, misalign_err}, 32'h0);

        // Loader pointer restarts at zero after the aborted load
        load_req = 1'b1;
        nxt();
        load_req = 1'b0;
        load_word(32'hDDDD_0001, 1'b1, 1'b1);
        chk("final_run", {30'h0, state}, 32'h2);

        chk("wq_empty", 32'(wq.size()), 32'h0);
        chk("fq_empty", 32'(fq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
